ppi_bus_master: RTL
===================

Name: ppi_bus_master

Overview:
- Host-side bus sequencer that sits directly upstream of the 8255 PPI core.
- Converts a single-cycle request/ready handshake from a CPU-like host into properly timed 8255 bus cycles: address, chip select, read/write strobes and data-bus enable.
- Returns read data plus a one-cycle acknowledge.
- The top level owns the DATA tristate; this block supplies DATA_OUT/DATA_OE and samples DATA_IN.

Parameters:
- SETUP_CYC, 1, cycles with CS_N/A (and write data) valid before the strobe falls; legal range 1..15
- STROBE_CYC, 2, cycles RD_N or WR_N is held low; legal range 1..15
- HOLD_CYC, 1, cycles CS_N/A/data held after the strobe rises; legal range 1..15
- RECOVER_CYC, 2, cycles CS_N high before the next access may start; legal range 1..15

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- REQ  in  1  host request; accepted when REQ=1 and READY=1 on the same edge
- WE  in  1  1 = write, 0 = read; sampled at acceptance
- ADDR  in  2  PPI register select (0 = A, 1 = B, 2 = C, 3 = control); sampled at acceptance
- WDATA  in  8  write data; sampled at acceptance
- READY  out  1  block idle and able to accept a request
- ACK  out  1  one-cycle pulse when the access completes
- RDATA  out  8  captured read data; held until the next read
- PPI_A  out  2  address to the PPI
- PPI_CS_N  out  1  chip select, active low
- PPI_RD_N  out  1  read strobe, active low
- PPI_WR_N  out  1  write strobe, active low
- PPI_DATA_OUT  out  8  write data toward DATA
- PPI_DATA_OE  out  1  1 = drive DATA
- PPI_DATA_IN  in  8  DATA bus value as seen from the PPI

Behaviour:
- Reset values (asynchronous, applied immediately, even mid-access):
  - state = IDLE
  - CS_N = RD_N = WR_N = 1
  - DATA_OE = 0, PPI_A = 0, DATA_OUT = 0
  - RDATA = 0, ACK = 0
  - READY = 1
  - REQ is ignored while RESET = 1.
- All PPI_* outputs come straight from flops, so they are glitch-free. READY = (state == IDLE).
- States and outputs:
  - IDLE: READY = 1; all strobes high. On acceptance, latch WE/ADDR/WDATA and go to SETUP.
  - SETUP (SETUP_CYC cycles): CS_N = 0, PPI_A = addr. On a write, DATA_OE = 1 and DATA_OUT = wdata. Then go to STROBE.
  - STROBE (STROBE_CYC cycles): adds RD_N = 0 for a read, or WR_N = 0 for a write. For a read, PPI_DATA_IN is sampled into RDATA on the edge that ends STROBE. Then go to HOLD.
  - HOLD (HOLD_CYC cycles): strobes high; CS_N, A and write data still driven. ACK = 1 in the first HOLD cycle only. Then go to RECOVER.
  - RECOVER (RECOVER_CYC cycles): CS_N = 1, DATA_OE = 0, PPI_A holds its value. Then go to IDLE.
- Latency and overlap rules:
  - Busy time per access is SETUP + STROBE + HOLD + RECOVER cycles from the edge after acceptance. Defaults give 6 cycles, so READY reasserts 6 cycles after acceptance.
  - RD_N and WR_N are never low together.
  - DATA_OE is never 1 during a read access.
- Host-side rules:
  - Back-to-back: if REQ is held high, the next request is accepted on the first edge where READY = 1 (the cycle IDLE is re-entered). No cycles are added beyond RECOVER.
  - REQ and WDATA changes while busy are ignored; there is no queuing.
- A single down-counter, 4 bits wide, is reloaded with (N-1) on every state entry; the state advances when the count is 0.
- Parameters outside 1..15 are an elaboration error.
- RDATA is unchanged by write accesses.

Decomposition:
- Package ppi_pkg:
  - state enum: IDLE, SETUP, STROBE, HOLD, RECOVER
  - address constants: PORT_A = 2'd0, PORT_B = 2'd1, PORT_C = 2'd2, CTRL = 2'd3
  - CW_ALL_INPUT = 8'h9B
  - BSR flag bit index = 7
- One sub-module, ppi_phase_counter: load value, load enable, decrement, zero flag.

Test Plan:
- Reset mid-access: assert RESET during STROBE of a write -> same timestep CS_N = WR_N = 1, DATA_OE = 0, READY = 1, ACK = 0.
- Control write with defaults: REQ, WE = 1, ADDR = 3, WDATA = 0x80 -> A = 3 and CS_N low 4 cycles, WR_N low exactly 2 cycles starting 1 cycle after CS_N, DATA_OUT = 0x80 with OE high for those 4 cycles, one ACK pulse, READY high 6 cycles after acceptance.
- Read Port A: DATA_IN = 0x5A during STROBE, changed to 0xFF after -> RDATA = 0x5A when ACK = 1, RD_N low 2 cycles, DATA_OE stays 0 throughout.
- Back-to-back: REQ held high for a write then a read -> CS_N high for exactly 2 cycles between accesses, two ACK pulses 6 cycles apart.
- Busy REQ ignored: one-cycle REQ pulse during HOLD -> exactly one bus access, one ACK.
- Custom timing SETUP = 3, STROBE = 5, HOLD = 2, RECOVER = 1 -> WR_N low exactly 5 cycles, CS_N low 10 cycles, READY returns after 11 cycles.

Source files
------------

// File: rtl/ppi_pkg.sv
// Shared types and constants for the 8255 PPI host-side bus sequencer.
package ppi_pkg;

    // Bus-cycle phases of one PPI access
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } state_t;

    // PPI register select values
    localparam logic [1:0] PORT_A = 2'd0;
    localparam logic [1:0] PORT_B = 2'd1;
    localparam logic [1:0] PORT_C = 2'd2;
    localparam logic [1:0] CTRL   = 2'd3;

    // Mode 0 control word with every port an input
    localparam logic [7:0] CW_ALL_INPUT = 8'h9B;

    // Control-word bit that selects mode set (1) versus bit set/reset (0)
    localparam int BSR_BIT = 7;

    // Phase counter width; holds up to 15 cycles per phase
    localparam int CNT_W = 4;

    // A phase of N cycles loads N-1 and advances once the count reaches zero
    function automatic logic [CNT_W-1:0] phase_load(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ppi_phase_counter.sv
// Down-counter that times each bus phase; zero marks the phase's last cycle.
module ppi_phase_counter
    import ppi_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    // Reload on phase entry, otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// Host request/ready handshake to timed 8255 bus cycles. Every PPI_* output
// is a flop loaded from the next state, so the bus pins never glitch.
module ppi_bus_master
    import ppi_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 2,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RECOVER_CYC = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ,
    input  logic       WE,
    input  logic [1:0] ADDR,
    input  logic [7:0] WDATA,
    output logic       READY,
    output logic       ACK,
    output logic [7:0] RDATA,
    output logic [1:0] PPI_A,
    output logic       PPI_CS_N,
    output logic       PPI_RD_N,
    output logic       PPI_WR_N,
    output logic [7:0] PPI_DATA_OUT,
    output logic       PPI_DATA_OE,
    input  logic [7:0] PPI_DATA_IN
);

    if ((SETUP_CYC < 1) || (SETUP_CYC > 15) || (STROBE_CYC < 1) || (STROBE_CYC > 15) ||
        (HOLD_CYC < 1) || (HOLD_CYC > 15) || (RECOVER_CYC < 1) || (RECOVER_CYC > 15)) begin : g_bad_timing
        $error("ppi_bus_master: every phase length must be within 1..15 cycles");
    end

    state_t           state_reg;
    state_t           state_next;
    logic             we_reg;
    logic             accept;
    logic             we_cur;
    logic             cs_active_next;
    logic             strobe_done;
    logic             phase_load_en;
    logic [CNT_W-1:0] phase_load_value;
    logic             phase_zero;

    ppi_phase_counter u_phase_counter (
        .clk        (CLK),
        .rst        (RESET),
        .load       (phase_load_en),
        .load_value (phase_load_value),
        .dec        (!phase_load_en),
        .zero       (phase_zero)
    );

    // Phase sequencing; a request still held when RECOVER ends is taken on the
    // very edge that would re-enter IDLE, so back-to-back accesses add no bubble
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (REQ) begin
                    state_next = SETUP;
                    accept     = 1'b1;
                end
            end
            SETUP:   if (phase_zero) state_next = STROBE;
            STROBE:  if (phase_zero) state_next = HOLD;
            HOLD:    if (phase_zero) state_next = RECOVER;
            RECOVER: begin
                if (phase_zero) begin
                    if (REQ) begin
                        state_next = SETUP;
                        accept     = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter reload value for the phase being entered
    always_comb begin
        phase_load_en    = (state_next != state_reg);
        phase_load_value = '0;
        case (state_next)
            SETUP:   phase_load_value = phase_load(SETUP_CYC);
            STROBE:  phase_load_value = phase_load(STROBE_CYC);
            HOLD:    phase_load_value = phase_load(HOLD_CYC);
            RECOVER: phase_load_value = phase_load(RECOVER_CYC);
            default: phase_load_value = '0;
        endcase
    end

    // Direction of the access that the next state belongs to
    assign we_cur         = accept ? WE : we_reg;
    assign cs_active_next = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);
    assign strobe_done    = (state_reg == STROBE) && phase_zero;
    assign READY          = (state_reg == IDLE);

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Access latches, registered bus pins, read capture and acknowledge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            we_reg       <= 1'b0;
            PPI_A        <= 2'd0;
            PPI_DATA_OUT <= 8'd0;
            PPI_CS_N     <= 1'b1;
            PPI_RD_N     <= 1'b1;
            PPI_WR_N     <= 1'b1;
            PPI_DATA_OE  <= 1'b0;
            RDATA        <= 8'd0;
            ACK          <= 1'b0;
        end else begin
            if (accept) begin
                we_reg <= WE;
                PPI_A  <= ADDR;
                if (WE) begin
                    PPI_DATA_OUT <= WDATA;
                end
            end
            PPI_CS_N    <= !cs_active_next;
            PPI_RD_N    <= !((state_next == STROBE) && !we_cur);
            PPI_WR_N    <= !((state_next == STROBE) && we_cur);
            PPI_DATA_OE <= cs_active_next && we_cur;
            ACK         <= strobe_done;
            if (strobe_done && !we_reg) begin
                RDATA <= PPI_DATA_IN;
            end
        end
    end

endmodule
